mic_spi_sampler: RTL and testbench



---
 rtl/mic_pkg.sv | 26 ++
 rtl/mic_sclk_gen.sv | 66 ++++++
 rtl/mic_spi_sampler.sv | 133 +++++++++++++
 tb/tb_mic_spi_sampler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared definitions for the Pmod MIC3 serial front end.
//   FRAME_BITS  - bits per ADC conversion frame (leading zeros + data)
//   DATA_BITS   - width of the delivered sample
//   LEAD_ZEROS  - leading bits the ADC drives low in a good frame
//   mic_state_e - frame sequencer states
package mic_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_ZEROS = 4;

    localparam int BIT_CNT_W = $clog2(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // cs_n high, waiting for a period boundary
        ST_CONV = 2'd1,  // cs_n low, clocking in the 16 frame bits
        ST_DONE = 2'd2   // last sclk high phase before releasing cs_n
    } mic_state_e;

    // A frame is suspect when the ADC drove any of its leading zeros high.
    function automatic logic lead_bits_set(input logic [FRAME_BITS-1:0] frame);
        return |frame[FRAME_BITS-1 -: LEAD_ZEROS];
    endfunction

endpackage

// File: rtl/mic_sclk_gen.sv
// Serial clock generator for the ADC interface.
// While run_i is high, sclk_o toggles every SCLK_HALF clk_in cycles, starting
// with a falling edge; while run_i is low it idles high and the phase counter
// is held at zero, so every frame starts with identical timing.
//   clk_in  - system clock
//   rst_n   - asynchronous active-low reset
//   run_i   - count and toggle sclk
//   park_i  - keep sclk high: falling edges are suppressed, fall_o still marks them
//   sclk_o  - registered serial clock
//   rise_o  - high in the cycle whose closing clk_in edge raises sclk_o
//   fall_o  - high in the cycle whose closing clk_in edge lowers (or would lower) sclk_o
module mic_sclk_gen #(
    parameter int SCLK_HALF = 5
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic run_i,
    input  logic park_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_HALF - 1);

    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic              sclk_q, sclk_d;
    logic              tick;

    assign tick   = run_i && (half_cnt_q == HALF_LAST);
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        // NOTE: hold-value defaults first, so no path through this block leaves a
        // signal unassigned and no latch is inferred.
        half_cnt_d = half_cnt_q;
        sclk_d     = sclk_q;
        if (!run_i) begin
            half_cnt_d = '0;
            sclk_d     = 1'b1;
        end else if (tick) begin
            half_cnt_d = '0;
            if (!(sclk_q && park_i)) begin
                sclk_d = !sclk_q;
            end
        end else begin
            half_cnt_d = half_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            sclk_q     <= 1'b1;
        end else begin
            half_cnt_q <= half_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

endmodule

// File: rtl/mic_spi_sampler.sv
// Serial front end for the Pmod MIC3 ADC (ADCS7476-style 16-bit frame:
// 4 leading zeros then 12 data bits, MSB first).
// Starts one conversion per SAMPLE_PERIOD clk_in cycles while en is high,
// shifts in sdata on each sclk rising edge and presents a held 12-bit sample.
//   clk_in       - system clock
//   rst_n        - asynchronous active-low reset
//   en           - conversion enable, sampled only at period boundaries
//   sdata        - ADC serial data
//   cs_n         - ADC chip select, active low, registered
//   sclk         - ADC serial clock, idles high, registered
//   sample       - last captured sample, held between updates
//   sample_valid - one-cycle pulse when sample updates
//   frame_err    - one-cycle pulse alongside sample_valid when a leading bit was 1
module mic_spi_sampler
    import mic_pkg::*;
#(
    parameter int SCLK_HALF     = 5,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err
);

    // A frame occupies 33 half periods; the period must leave room for it plus
    // an idle gap with cs_n high.
    if (SCLK_HALF < 2 || SAMPLE_PERIOD < 34 * SCLK_HALF + 2) begin : g_param_check
        $error("mic_spi_sampler: need SCLK_HALF >= 2 and SAMPLE_PERIOD >= 34*SCLK_HALF+2");
    end

    localparam int PER_W = $clog2(SAMPLE_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    logic [PER_W-1:0]      period_q, period_d;
    mic_state_e            state_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  cs_n_q;
    logic [DATA_BITS-1:0]  sample_q;
    logic                  valid_q;
    logic                  ferr_q;

    logic sclk_run, sclk_park, sclk_rise, sclk_fall;

    // Free-running period counter, independent of en and the frame state, so
    // conversion starts stay on an exact SAMPLE_PERIOD grid.
    always_comb begin
        period_d = (period_q == PER_LAST) ? '0 : period_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    // The generator starts counting the cycle after cs_n falls, which puts the
    // first sclk fall SCLK_HALF cycles after cs_n. In DONE it keeps sclk high
    // and its fall strobe marks the end of the final half period.
    assign sclk_run  = (state_q != ST_IDLE);
    assign sclk_park = (state_q == ST_DONE);

    mic_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .run_i  (sclk_run),
        .park_i (sclk_park),
        .sclk_o (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (period_q == '0 && en) begin
                        state_q   <= ST_CONV;
                        cs_n_q    <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_CONV: begin
                    // sdata is taken on the same clk_in edge that raises sclk,
                    // i.e. the value the ADC has held since the previous fall.
                    if (sclk_rise) begin
                        shift_q   <= {shift_q[FRAME_BITS-2:0], sdata};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (sclk_fall) begin
                        state_q  <= ST_IDLE;
                        cs_n_q   <= 1'b1;
                        sample_q <= shift_q[DATA_BITS-1:0];
                        valid_q  <= 1'b1;
                        ferr_q   <= lead_bits_set(shift_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cs_n         = cs_n_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_mic_spi_sampler.sv
`timescale 1ns/1ps
// Bench for mic_spi_sampler: a default-parameter instance (A) and a fast one
// (B, SCLK_HALF=2, SAMPLE_PERIOD=70), each fed by a behavioural ADC model.
module tb_mic_spi_sampler;

    localparam int H_A = 5;
    localparam int P_A = 5000;
    localparam int H_B = 2;
    localparam int P_B = 70;

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp_sample;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          pc;          // modelled DUT period counter (post-edge)
        int          pc_before;   // its value before the latest edge
        int          t0;
        int          pc_at_fall;
        int          starts;
        int          rises;
        int          falls;
        bit          timing_bad;
        int          cs_rise_d;
        bit          in_frame;
        int          valid_cnt;
        int          valid_t;
        int          valid_d;
        logic [11:0] v_sample;
        logic        v_err;
        bit          width_bad;
        bit          held_bad;
        bit          idle_bad;
        bit          err_bad;
        logic        prev_cs;
        logic        prev_sclk;
        logic        prev_valid;
        logic [11:0] prev_sample;
    } mon_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, en_a, sdata_a, cs_n_a, sclk_a, valid_a, ferr_a;
    logic [11:0] sample_a;
    logic        rst_n_b, en_b, sdata_b, cs_n_b, sclk_b, valid_b, ferr_b;
    logic [11:0] sample_b;
    logic [15:0] adc_word_a, adc_word_b;
    int          idx_a, idx_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;
    mon_t mon [2];

    mic_spi_sampler #(.SCLK_HALF(H_A), .SAMPLE_PERIOD(P_A)) u_dut_a (
        .clk_in       (clk),
        .rst_n        (rst_n_a),
        .en           (en_a),
        .sdata        (sdata_a),
        .cs_n         (cs_n_a),
        .sclk         (sclk_a),
        .sample       (sample_a),
        .sample_valid (valid_a),
        .frame_err    (ferr_a)
    );

    mic_spi_sampler #(.SCLK_HALF(H_B), .SAMPLE_PERIOD(P_B)) u_dut_b (
        .clk_in       (clk),
        .rst_n        (rst_n_b),
        .en           (en_b),
        .sdata        (sdata_b),
        .cs_n         (cs_n_b),
        .sclk         (sclk_b),
        .sample       (sample_b),
        .sample_valid (valid_b),
        .frame_err    (ferr_b)
    );

    // ADC models: cs_n fall rewinds to the MSB, each sclk fall presents the next bit.
    always @(negedge cs_n_a or negedge sclk_a) begin
        if (sclk_a) idx_a = 15;
        else if (!cs_n_a && idx_a >= 0) begin
            sdata_a = adc_word_a[idx_a];
            idx_a   = idx_a - 1;
        end
    end

    always @(negedge cs_n_b or negedge sclk_b) begin
        if (sclk_b) idx_b = 15;
        else if (!cs_n_b && idx_b >= 0) begin
            sdata_b = adc_word_b[idx_b];
            idx_b   = idx_b - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_step(input int g, input int h, input int p, input logic rst,
                            input logic cs, input logic sk, input logic v,
                            input logic [11:0] s, input logic fe);
        int d;
        if (!rst) begin
            mon[g].pc       = 0;
            mon[g].in_frame = 0;
        end else begin
            mon[g].pc_before = mon[g].pc;
            mon[g].pc        = (mon[g].pc == p - 1) ? 0 : mon[g].pc + 1;
            if (mon[g].prev_cs && !cs) begin
                mon[g].in_frame   = 1;
                mon[g].t0         = cyc;
                mon[g].pc_at_fall = mon[g].pc_before;
                mon[g].starts++;
                mon[g].rises      = 0;
                mon[g].falls      = 0;
                mon[g].timing_bad = 0;
                mon[g].cs_rise_d  = -1;
            end
            d = cyc - mon[g].t0;
            if (mon[g].in_frame && sk !== mon[g].prev_sclk) begin
                if (!sk) begin
                    if (d != h * (2 * mon[g].falls + 1)) mon[g].timing_bad = 1;
                    mon[g].falls++;
                end else begin
                    if (d != h * (2 * mon[g].rises + 2)) mon[g].timing_bad = 1;
                    mon[g].rises++;
                end
            end
            if (!mon[g].prev_cs && cs && mon[g].in_frame) begin
                mon[g].cs_rise_d = d;
                mon[g].in_frame  = 0;
            end
            if (cs && !sk) mon[g].idle_bad = 1;
            if (v) begin
                if (mon[g].prev_valid) mon[g].width_bad = 1;
                mon[g].valid_cnt++;
                mon[g].valid_t  = cyc;
                mon[g].valid_d  = d;
                mon[g].v_sample = s;
                mon[g].v_err    = fe;
            end else begin
                if (s !== mon[g].prev_sample) mon[g].held_bad = 1;
                if (fe) mon[g].err_bad = 1;
            end
        end
        mon[g].prev_cs     = cs;
        mon[g].prev_sclk   = sk;
        mon[g].prev_valid  = v;
        mon[g].prev_sample = s;
    endtask

    // Monitor: cyc is the index of the latest rising edge; sampled 1 ns after it.
    initial begin
        cyc = 0;
        for (int g = 0; g < 2; g++) begin
            mon[g] = '{default: 0};
            mon[g].prev_cs   = 1'b1;
            mon[g].prev_sclk = 1'b1;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mon_step(0, H_A, P_A, rst_n_a, cs_n_a, sclk_a, valid_a, sample_a, ferr_a);
            mon_step(1, H_B, P_B, rst_n_b, cs_n_b, sclk_b, valid_b, sample_b, ferr_b);
        end
    end

    task automatic wait_valid(input int g, input int budget);
        int base;
        bit got;
        base = mon[g].valid_cnt;
        got  = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (mon[g].valid_cnt != base) got = 1;
        end
        check($sformatf("valid_seen%0d", g), 32'(got), 32'd1);
    endtask

    task automatic wait_start(input int g, input int budget);
        int base;
        bit got;
        base = mon[g].starts;
        got  = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (mon[g].starts != base) got = 1;
        end
        check($sformatf("start_seen%0d", g), 32'(got), 32'd1);
    endtask

    task automatic wait_pc(input int g, input int value, input int budget);
        bit got;
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (mon[g].pc == value) got = 1;
        end
        check($sformatf("pc_reached_%0d", value), 32'(got), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int g, input int h,
                               input logic [11:0] exp_s, input logic exp_e);
        check({tag, "_valid_time"}, 32'(mon[g].valid_d), 32'(33 * h));
        check({tag, "_cs_rise"},    32'(mon[g].cs_rise_d), 32'(33 * h));
        check({tag, "_sample"},     32'(mon[g].v_sample), 32'(exp_s));
        check({tag, "_frame_err"},  32'(mon[g].v_err), 32'(exp_e));
        check({tag, "_rises"},      32'(mon[g].rises), 32'd16);
        check({tag, "_falls"},      32'(mon[g].falls), 32'd16);
        check({tag, "_sclk_timing"}, 32'(mon[g].timing_bad), 32'd0);
        check({tag, "_start_pc"},   32'(mon[g].pc_at_fall), 32'd0);
    endtask

    initial begin
        vec_t vecs_a [5];
        vec_t vecs_b [3];
        int   prev_t, en_cyc, rel_cyc, vsave, ssave;

        vecs_a[0] = '{16'h0ABC, 12'hABC, 1'b0};
        vecs_a[1] = '{16'h0FFF, 12'hFFF, 1'b0};
        vecs_a[2] = '{16'h0000, 12'h000, 1'b0};
        vecs_a[3] = '{16'h0800, 12'h800, 1'b0};
        vecs_a[4] = '{16'h9123, 12'h123, 1'b1};
        vecs_b[0] = '{16'h0A5A, 12'hA5A, 1'b0};
        vecs_b[1] = '{16'h8001, 12'h001, 1'b1};
        vecs_b[2] = '{16'h0FFF, 12'hFFF, 1'b0};

        rst_n_a = 0; en_a = 0; rst_n_b = 0; en_b = 0;
        adc_word_a = vecs_a[0].word;
        adc_word_b = vecs_b[0].word;
        repeat (3) @(negedge clk);

        check("reset_cs_n",   32'(cs_n_a), 32'd1);
        check("reset_sclk",   32'(sclk_a), 32'd1);
        check("reset_sample", 32'(sample_a), 32'd0);
        check("reset_valid",  32'(valid_a), 32'd0);
        check("reset_ferr",   32'(ferr_a), 32'd0);

        // Back-to-back frames from the vector table.
        en_a = 1; rst_n_a = 1;
        prev_t = 0;
        for (int i = 0; i < 5; i++) begin
            wait_valid(0, P_A + 100);
            check_frame($sformatf("vec%0d", i), 0, H_A, vecs_a[i].exp_sample, vecs_a[i].exp_err);
            if (i > 0) check($sformatf("vec%0d_spacing", i), 32'(mon[0].valid_t - prev_t), 32'(P_A));
            prev_t = mon[0].valid_t;
            adc_word_a = (i < 4) ? vecs_a[i + 1].word : 16'h0321;
            @(negedge clk);
            check($sformatf("vec%0d_pulse_end", i), 32'(valid_a), 32'd0);
            check($sformatf("vec%0d_held", i), 32'(sample_a), 32'(vecs_a[i].exp_sample));
        end

        // en dropped mid-frame: frame still delivered, next wrap skipped.
        wait_start(0, P_A + 100);
        while (cyc < mon[0].t0 + 50) @(negedge clk);
        en_a = 0;
        wait_valid(0, 400);
        check_frame("en_drop", 0, H_A, 12'h321, 1'b0);
        ssave = mon[0].starts;
        vsave = mon[0].valid_cnt;
        wait_pc(0, 0, P_A + 10);
        wait_pc(0, 2000, P_A + 10);
        check("en_low_no_start", 32'(mon[0].starts), 32'(ssave));
        check("en_low_no_valid", 32'(mon[0].valid_cnt), 32'(vsave));
        adc_word_a = 16'h0C0F;
        en_a = 1;
        en_cyc = cyc;
        wait_start(0, P_A + 10);
        check("en_rise_start_delay", 32'(mon[0].t0 - en_cyc), 32'(P_A - 2000 + 1));
        wait_valid(0, 400);
        check_frame("en_rise", 0, H_A, 12'hC0F, 1'b0);

        // Reset mid-frame.
        adc_word_a = 16'h0777;
        wait_start(0, P_A + 100);
        while (cyc < mon[0].t0 + 80) @(negedge clk);
        vsave = mon[0].valid_cnt;
        rst_n_a = 0;
        #1;
        check("midrst_cs_n",   32'(cs_n_a), 32'd1);
        check("midrst_sclk",   32'(sclk_a), 32'd1);
        check("midrst_sample", 32'(sample_a), 32'd0);
        check("midrst_valid",  32'(valid_a), 32'd0);
        repeat (3) @(negedge clk);
        adc_word_a = 16'h0456;
        rst_n_a = 1;
        rel_cyc = cyc;
        wait_valid(0, P_A + 400);
        check("midrst_one_pulse", 32'(mon[0].valid_cnt), 32'(vsave + 1));
        check("midrst_restart",   32'(mon[0].t0 - rel_cyc), 32'd1);
        check_frame("after_rst", 0, H_A, 12'h456, 1'b0);

        // Fast instance: SCLK_HALF=2, SAMPLE_PERIOD=70.
        rst_n_b = 1; en_b = 1;
        prev_t = 0;
        for (int i = 0; i < 3; i++) begin
            wait_valid(1, P_B + 20);
            check_frame($sformatf("fast%0d", i), 1, H_B, vecs_b[i].exp_sample, vecs_b[i].exp_err);
            if (i > 0) check($sformatf("fast%0d_spacing", i), 32'(mon[1].valid_t - prev_t), 32'(P_B));
            prev_t = mon[1].valid_t;
            if (i < 2) adc_word_b = vecs_b[i + 1].word;
        end

        for (int g = 0; g < 2; g++) begin
            check($sformatf("valid_single_cycle%0d", g), 32'(mon[g].width_bad), 32'd0);
            check($sformatf("sample_held%0d", g),        32'(mon[g].held_bad), 32'd0);
            check($sformatf("sclk_high_when_idle%0d", g), 32'(mon[g].idle_bad), 32'd0);
            check($sformatf("ferr_only_with_valid%0d", g), 32'(mon[g].err_bad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
